// File: rtl/ivl_uvm_ovl_pkg.sv
// Shared definitions for the OVL fire collector: fire-bit positions and the event record.
package ivl_uvm_ovl_pkg;

    localparam int FIRE_ASSERT = 0;
    localparam int FIRE_XCHK   = 1;
    localparam int FIRE_COVER  = 2;

    localparam int EVT_ID_W = 8;
    localparam int EVT_TS_W = 32;

    // Reference event layout at default widths; the collector builds a width-exact copy.
    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic [2:0]          typ;
        logic [EVT_TS_W-1:0] ts;
    } evt_t;

endpackage

// File: rtl/ivl_uvm_sync_fifo.sv
// Show-ahead synchronous FIFO with sync flush; a push into a full FIFO is accepted when a pop frees a slot.
module ivl_uvm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// Collects OVL checker fire buses into sticky status, a saturating failure count,
// a first-failure record and a timestamped event stream for the UVM monitor.
module ivl_uvm_ovl_fire_collector
    import ivl_uvm_ovl_pkg::*;
#(
    parameter int NUM_CHK    = 8,
    parameter int CNT_W      = 8,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 16,
    localparam int ID_W      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [3*NUM_CHK-1:0] fire_vec,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [ID_W-1:0]      evt_id,
    output logic [2:0]           evt_type,
    output logic [TS_W-1:0]      evt_ts,
    output logic [NUM_CHK-1:0]   fail_mask,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 first_vld,
    output logic [ID_W-1:0]      first_id,
    output logic [TS_W-1:0]      first_ts,
    output logic                 evt_lost
);
    localparam int CW = CNT_W + ID_W + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [2:0]      typ;
        logic [TS_W-1:0] ts;
    } ent_t;

    logic [TS_W-1:0]              stamp;
    logic [NUM_CHK-1:0][2:0]      fire;
    logic [NUM_CHK-1:0]           hit, fail;
    logic [NUM_CHK-1:0]           occ;
    logic [NUM_CHK-1:0][2:0]      p_typ;
    logic [NUM_CHK-1:0][TS_W-1:0] p_ts;
    logic [NUM_CHK-1:0]           drain_oh;
    logic                         drain_any, push, pop, fifo_full, fifo_empty;
    ent_t                         drain_ent, head;
    logic [ID_W-1:0]              first_sel;
    logic [CW-1:0]                fail_sum, cnt_sum;
    logic [CNT_W-1:0]             cnt_nxt;

    assign fire = fire_vec;

    always_comb begin
        hit  = '0;
        fail = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            hit[i]  = enable && (|fire[i]);
            fail[i] = enable && (fire[i][FIRE_ASSERT] || fire[i][FIRE_XCHK]);
        end
    end

    // Descending scans so the lowest index is the one left standing.
    always_comb begin
        drain_any = 1'b0;
        drain_ent = '0;
        first_sel = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (occ[i]) begin
                drain_any     = 1'b1;
                drain_ent.id  = ID_W'(i);
                drain_ent.typ = p_typ[i];
                drain_ent.ts  = p_ts[i];
            end
            if (fail[i]) first_sel = ID_W'(i);
        end
    end

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign push      = drain_any && (!fifo_full || pop) && !clear;

    always_comb begin
        drain_oh = '0;
        for (int i = 0; i < NUM_CHK; i++)
            if (push && drain_ent.id == ID_W'(i)) drain_oh[i] = 1'b1;
    end

    always_comb begin
        fail_sum = '0;
        for (int i = 0; i < NUM_CHK; i++) fail_sum = fail_sum + CW'(fail[i]);
        cnt_sum = fail_sum + CW'(fail_cnt);
        cnt_nxt = (cnt_sum > CW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       stamp <= '0;
        else if (enable) stamp <= stamp + 1'b1;
    end

    // A slot draining this edge counts as free, so a new fire reloads it rather than merging.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ      <= '0;
            p_typ    <= '0;
            p_ts     <= '0;
            evt_lost <= 1'b0;
        end else if (clear) begin
            occ      <= '0;
            p_typ    <= '0;
            p_ts     <= '0;
            evt_lost <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHK; i++) begin
                if (hit[i]) begin
                    if (occ[i] && !drain_oh[i]) begin
                        p_typ[i] <= p_typ[i] | fire[i];
                    end else begin
                        occ[i]   <= 1'b1;
                        p_typ[i] <= fire[i];
                        p_ts[i]  <= stamp;
                    end
                end else if (drain_oh[i]) begin
                    occ[i] <= 1'b0;
                end
            end
            if (|(hit & occ & ~drain_oh)) evt_lost <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fail_mask <= '0;
            fail_cnt  <= '0;
            first_vld <= 1'b0;
            first_id  <= '0;
            first_ts  <= '0;
        end else if (clear) begin
            fail_mask <= '0;
            fail_cnt  <= '0;
            first_vld <= 1'b0;
            first_id  <= '0;
            first_ts  <= '0;
        end else if (enable) begin
            fail_mask <= fail_mask | fail;
            fail_cnt  <= cnt_nxt;
            if (!first_vld && (|fail)) begin
                first_vld <= 1'b1;
                first_id  <= first_sel;
                first_ts  <= stamp;
            end
        end
    end

    ivl_uvm_sync_fifo #(
        .WIDTH ($bits(ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .din   (drain_ent),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FIFO storage is not reset, so the head is masked until it holds a real entry.
    assign evt_id   = evt_valid ? head.id  : '0;
    assign evt_type = evt_valid ? head.typ : '0;
    assign evt_ts   = evt_valid ? head.ts  : '0;

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
// Bench for ivl_uvm_ovl_fire_collector: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based event model.
module tb_ivl_uvm_ovl_fire_collector;
    localparam int N  = 4;
    localparam int CW = 4;
    localparam int TW = 8;
    localparam int FD = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          clear = 1'b0;
    logic [3*N-1:0] fire_vec = '1;
    logic          evt_ready = 1'b1;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic [2:0]    evt_type;
    logic [TW-1:0] evt_ts;
    logic [N-1:0]  fail_mask;
    logic [CW-1:0] fail_cnt;
    logic          first_vld;
    logic [1:0]    first_id;
    logic [TW-1:0] first_ts;
    logic          evt_lost;

    ivl_uvm_ovl_fire_collector #(
        .NUM_CHK(N), .CNT_W(CW), .TS_W(TW), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .fire_vec(fire_vec), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_type(evt_type), .evt_ts(evt_ts),
        .fail_mask(fail_mask), .fail_cnt(fail_cnt), .first_vld(first_vld),
        .first_id(first_id), .first_ts(first_ts), .evt_lost(evt_lost)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [1:0]    id;
        logic [2:0]    typ;
        logic [TW-1:0] ts;
    } ev_t;

    ev_t           q[$];
    bit            m_occ [N];
    logic [2:0]    m_typ [N];
    logic [TW-1:0] m_ts  [N];
    logic [TW-1:0] m_stamp = '0;
    logic [N-1:0]  m_mask = '0;
    int            m_cnt = 0;
    bit            m_first = 0;
    logic [1:0]    m_fid = '0;
    logic [TW-1:0] m_fts = '0;
    bit            m_lost = 0;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            m_occ[i] = 0; m_typ[i] = '0; m_ts[i] = '0;
        end
        m_stamp = '0; m_mask = '0; m_cnt = 0; m_first = 0; m_fid = '0; m_fts = '0; m_lost = 0;
    endtask

    initial model_reset();

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            bit   do_pop;
            int   d;
            int   nf;
            ev_t  e;
            logic [2:0] f;
            do_pop = (q.size() > 0) && evt_ready;
            d = -1;
            for (int i = 0; i < N; i++) if (m_occ[i] && d < 0) d = i;
            if (clear) begin
                q.delete();
                for (int i = 0; i < N; i++) m_occ[i] = 0;
                m_mask = '0; m_cnt = 0; m_first = 0; m_fid = '0; m_fts = '0; m_lost = 0;
            end else begin
                if (do_pop) void'(q.pop_front());
                if (d >= 0 && (q.size() < FD)) begin
                    e.id = 2'(d); e.typ = m_typ[d]; e.ts = m_ts[d];
                    q.push_back(e);
                    m_occ[d] = 0;
                end
                if (enable) begin
                    nf = 0;
                    for (int i = 0; i < N; i++) begin
                        f = fire_vec[3*i +: 3];
                        if (f != 0) begin
                            if (m_occ[i]) begin
                                m_typ[i] = m_typ[i] | f;
                                m_lost = 1;
                            end else begin
                                m_occ[i] = 1; m_typ[i] = f; m_ts[i] = m_stamp;
                            end
                        end
                        if (f[0] || f[1]) begin
                            if (nf == 0 && !m_first) begin
                                m_first = 1; m_fid = 2'(i); m_fts = m_stamp;
                            end
                            nf++;
                            m_mask[i] = 1'b1;
                        end
                    end
                    m_cnt = (m_cnt + nf > 15) ? 15 : m_cnt + nf;
                end
            end
            if (enable) m_stamp = m_stamp + 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic [13:0] exp_evt;
        exp_evt = '0;
        if (q.size() > 0) exp_evt = {1'b1, q[0].id, q[0].typ, q[0].ts};
        chk("evt_bus", {evt_valid, evt_id, evt_type, evt_ts}, exp_evt);
        chk("status", {fail_mask, fail_cnt, first_vld, first_id, first_ts, evt_lost},
            {m_mask, 4'(m_cnt), m_first, m_fid, m_fts, m_lost});
    end

    // Advance n clocks; return just after the negedge compare so the next inputs hit a clean edge.
    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    initial begin
        // 1: reset held with every fire bit set
        step(3);
        chk("rst_outputs", {evt_valid, evt_id, evt_type, evt_ts, fail_mask, fail_cnt,
                            first_vld, first_id, first_ts, evt_lost}, 64'd0);
        reset = 1'b0;
        fire_vec = '0;

        // 2: chk2 assert fail sampled at stamp 5
        step(5);
        fire_vec = 12'h040;
        step(1);
        fire_vec = '0;
        chk("t2_mask", fail_mask, 64'h4);
        chk("t2_cnt", fail_cnt, 64'd1);
        chk("t2_first", {first_vld, first_id, first_ts}, {1'b1, 2'd2, 8'd5});
        chk("t2_no_evt_yet", evt_valid, 64'd0);
        step(1);
        chk("t2_evt", {evt_valid, evt_id, evt_type, evt_ts}, {1'b1, 2'd2, 3'b001, 8'd5});

        // 3: chk1 and chk3 together at stamp 10 after a clear at stamp 7
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(2);
        fire_vec = 12'h208;
        step(1);
        fire_vec = '0;
        chk("t3_first", {first_vld, first_id, first_ts}, {1'b1, 2'd1, 8'd10});
        chk("t3_cnt_mask", {fail_cnt, fail_mask}, {4'd2, 4'b1010});
        step(1);
        chk("t3_evt_a", {evt_valid, evt_id, evt_type, evt_ts}, {1'b1, 2'd1, 3'b001, 8'd10});
        step(1);
        chk("t3_evt_b", {evt_valid, evt_id, evt_type, evt_ts}, {1'b1, 2'd3, 3'b001, 8'd10});
        step(1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;

        // 4: consumer stalled while chk0 fires 6 cycles in a row (stamps 15..20)
        evt_ready = 1'b0;
        fire_vec = 12'h001;
        step(6);
        fire_vec = '0;
        chk("t4_cnt", fail_cnt, 64'd6);
        chk("t4_lost", evt_lost, 64'd1);
        chk("t4_head", {evt_valid, evt_id, evt_type, evt_ts}, {1'b1, 2'd0, 3'b001, 8'd15});
        evt_ready = 1'b1;
        step(8);

        // 5: saturation, then clear
        fire_vec = 12'h001;
        step(20);
        fire_vec = '0;
        chk("t5_sat", fail_cnt, 64'hF);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t5_cleared", {evt_valid, fail_mask, fail_cnt, first_vld, evt_lost}, 64'd0);

        // 6: cover-only event, then async reset while events are queued
        fire_vec = 12'h800;
        step(1);
        fire_vec = '0;
        step(1);
        chk("t6_cover_evt", {evt_valid, evt_id, evt_type}, {1'b1, 2'd3, 3'b100});
        chk("t6_no_fail", {fail_mask, fail_cnt, first_vld}, 64'd0);
        fire_vec = 12'h924;
        step(1);
        fire_vec = '0;
        step(1);
        chk("t6_draining", evt_valid, 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_async_rst", {evt_valid, evt_id, evt_type, evt_ts, fail_mask, fail_cnt,
                             first_vld, first_id, first_ts, evt_lost}, 64'd0);
        step(2);
        reset = 1'b0;

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            logic [3*N-1:0] fv;
            fv = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) fv[3*i +: 3] = 3'($urandom_range(1, 7));
            fire_vec  = fv;
            enable    = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            evt_ready = ($urandom_range(0, 9) < 6);
            reset     = ($urandom_range(0, 799) == 0);
            step(1);
        end
        reset = 1'b0;
        clear = 1'b0;
        fire_vec = '0;
        evt_ready = 1'b1;
        step(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
